// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default stability window for the 50 MHz board oscillator.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  // 1 ms of stability at 50 MHz
  localparam int unsigned DEFAULT_STABLE_COUNT = 32'd50000;
  localparam int unsigned DEFAULT_CNT_W        = 32'd21;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reusable for any
// board switch input. Resets both stages to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync0_q;

  // Metastability filter: the first stage may go metastable, the second settles it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync0_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync0_q <= sync1_q;
    end
  end

  assign q_o = sync0_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronises a bouncing button level and turns
// stable transitions into a clean level plus single-cycle press/release strobes.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic CLK_in,
  input  logic RST_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 32'd1);

  logic             sync0_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  sync_2ff u_sync (
    .clk_i  (CLK_in),
    .rst_ni (RST_n),
    .d_i    (btn_in),
    .q_o    (sync0_s)
  );

  // Counter increment; only used in WAIT states below CNT_LAST, so it never wraps
  always_comb begin
    cnt_inc_d = cnt_q + CNT_ONE;
  end

  // Debounce FSM with registered level and strobes
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync0_s) begin
            state_q <= ST_WAIT_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync0_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_inc_d;
          end
        end
        ST_PRESSED: begin
          if (!sync0_s) begin
            state_q <= ST_WAIT_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (sync0_s) begin
            state_q   <= ST_PRESSED;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with a sliding-window reference model:
// the level flips once the last STABLE_COUNT synchronised samples all disagree with it.
module tb_btn_debounce;

  localparam int SC = 4;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int total;
  int bad;

  btn_debounce #(
    .STABLE_COUNT (SC),
    .CNT_W        (4)
  ) dut (
    .CLK_in      (clk),
    .RST_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two-edge input delay, then a window of the last SC samples
  logic m_d1, m_d2, m_level, m_press, m_release;
  logic hist[$];

  always @(posedge clk or negedge rst_n) begin
    logic seen;
    logic flip;
    if (!rst_n) begin
      m_d1 = 1'b0; m_d2 = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0;
      hist.delete();
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_in;
      hist.push_back(seen);
      if (hist.size() > SC) void'(hist.pop_front());
      m_press = 1'b0;
      m_release = 1'b0;
      flip = (hist.size() == SC);
      foreach (hist[k]) if (hist[k] == m_level) flip = 1'b0;
      if (flip) begin
        m_level = ~m_level;
        if (m_level) m_press = 1'b1;
        else m_release = 1'b1;
      end
    end
  end

  task automatic test_reset();
    logic [2:0] got, want;
    rst_n = 1'b0;
    btn_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release};
      total++;
      if (got !== 3'b000) begin
        bad++; $display("FAIL reset_hold got=%b want=000", got);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = {(e >= SC + 2), (e == SC + 2), 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL reset_release e=%0d got=%b want=%b", e, got, want);
      end
      total++;
      if (got !== {m_level, m_press, m_release}) begin
        bad++; $display("FAIL reset_model e=%0d got=%b model=%b", e, got, {m_level, m_press, m_release});
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] got, want;
    btn_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = {(e < SC + 2), 1'b0, (e == SC + 2)};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL release e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] got, want;
    btn_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = {(e >= SC + 2), (e == SC + 2), 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL clean_press e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  task automatic test_short_glitch();
    logic [2:0] got;
    for (int c = 0; c < 15; c++) begin
      btn_in = (c < SC - 1) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release};
      total++;
      if (got !== 3'b100) begin
        bad++; $display("FAIL short_glitch c=%0d got=%b want=100", c, got);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] got, want;
    logic pat [8];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 20; c++) begin
      btn_in = (c < 8) ? pat[c] : 1'b1;
      @(posedge clk); #1;
      // last 0->1 change is driven at c=5, so acceptance lands on edge 5+SC+2
      want = {(c + 1 >= 5 + SC + 2), (c + 1 == 5 + SC + 2), 1'b0};
      got  = {btn_level, btn_press, btn_release};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL bounce c=%0d got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, want;
    btn_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release};
      total++;
      if (got !== 3'b000) begin
        bad++; $display("FAIL mid_precount got=%b want=000", got);
      end
    end
    rst_n = 1'b0;
    #1;
    got = {btn_level, btn_press, btn_release};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL mid_in_reset got=%b want=000", got);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      got  = {btn_level, btn_press, btn_release};
      want = {(e >= SC + 2), (e == SC + 2), 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL mid_recount e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] got, mdl;
    int cyc;
    int dut_press, mdl_press;
    cyc = 0;
    dut_press = 0;
    mdl_press = 0;
    while (cyc < 600) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * SC + 2);
      if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
      for (int k = 0; k < len; k++) begin
        btn_in = v;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        got = {btn_level, btn_press, btn_release};
        mdl = {m_level, m_press, m_release};
        dut_press += int'(btn_press);
        mdl_press += int'(m_press);
        total++;
        if (got !== mdl) begin
          bad++; $display("FAIL random cyc=%0d got=%b model=%b", cyc, got, mdl);
        end
        total++;
        if ((btn_press & btn_release) !== 1'b0) begin
          bad++; $display("FAIL random_both_strobes cyc=%0d press=%b release=%b", cyc, btn_press, btn_release);
        end
      end
    end
    total++;
    if (dut_press != mdl_press) begin
      bad++; $display("FAIL random_press_count got=%0d want=%0d", dut_press, mdl_press);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    btn_in = 1'b0;
    test_reset();
    test_release();
    test_clean_press();
    test_short_glitch();
    test_release();
    test_bounce();
    test_release();
    test_reset_mid();
    test_release();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
